// File: rtl/fe_decode_queue_pkg.sv
// Shared front-end constants and the fetch request record used by the
// decode queue and its ring buffer.
package fe_decode_queue_pkg;

  localparam int DECODED_INSTRUCTION_WIDTH = 32;
  localparam int WORD_SIZE_P               = 16;
  localparam logic [WORD_SIZE_P-1:0] RESET_PC_P = '0;
  localparam int FE_QUEUE_DEPTH            = 8;

  typedef struct packed {
    logic [WORD_SIZE_P-1:0] pc;
    logic                   epoch;
  } fe_req_t;

endpackage

// File: rtl/fe_ring_buffer.sv
// Power-of-two ring queue of decoded instructions; flush empties it in one cycle.
// Full/empty come from the occupancy count rather than from comparing pointers.
module fe_ring_buffer
  import fe_decode_queue_pkg::*;
#(
  parameter int DEPTH_P = FE_QUEUE_DEPTH,
  parameter int WIDTH_P = DECODED_INSTRUCTION_WIDTH,
  localparam int PTR_W  = $clog2(DEPTH_P),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               enq_v,
  input  logic [WIDTH_P-1:0] enq_data,
  input  logic               deq_v,
  output logic [WIDTH_P-1:0] head_data,
  output logic [CNT_W-1:0]   count
);

  logic [WIDTH_P-1:0] mem [DEPTH_P];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic               do_deq;

  assign do_deq    = deq_v && (count != '0);
  assign head_data = mem[head_q];

  always_ff @(posedge clk) begin
    if (enq_v && !flush && !reset) begin
      mem[tail_q] <= enq_data;
    end
  end

  // Pointers wrap on their own because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
    end else begin
      if (enq_v) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (do_deq) begin
        head_q <= head_q + PTR_W'(1);
      end
      count <= count + CNT_W'(enq_v) - CNT_W'(do_deq);
    end
  end

endmodule

// File: rtl/fe_decode_queue.sv
// Front-end fetch PC generator with epoch tagging and a credit-checked decode queue.
// Optional same-cycle bypass of an empty queue: define FE_QUEUE_BYPASS_EN.
module fe_decode_queue #(
  parameter int QUEUE_DEPTH_P = fe_decode_queue_pkg::FE_QUEUE_DEPTH,
  parameter int WORD_SIZE_P   = fe_decode_queue_pkg::WORD_SIZE_P,
  parameter int PC_STEP_P     = 2,
  parameter logic [WORD_SIZE_P-1:0] RESET_PC_P = WORD_SIZE_P'(fe_decode_queue_pkg::RESET_PC_P),
  localparam int INSTR_W      = fe_decode_queue_pkg::DECODED_INSTRUCTION_WIDTH,
  localparam int CNT_W        = $clog2(QUEUE_DEPTH_P) + 1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  output logic                   fetch_v_o,
  output logic [WORD_SIZE_P-1:0] fetch_pc_o,
  output logic                   fetch_epoch_o,
  input  logic                   fetch_ready_i,
  input  logic                   dec_v_i,
  input  logic                   dec_epoch_i,
  input  logic [INSTR_W-1:0]     dec_instr_i,
  output logic [INSTR_W-1:0]     decoded_o,
  output logic                   decoded_v_o,
  input  logic                   rename_decode_ready_i,
  input  logic                   be_fe_mispredict_i,
  input  logic [WORD_SIZE_P-1:0] be_fe_redirected_pc_i
);

  logic [WORD_SIZE_P-1:0] pc_q;
  logic                   epoch_q;
  logic [CNT_W-1:0]       inflight_q;
  logic [CNT_W-1:0]       count;
  logic [INSTR_W-1:0]     head_data;
  logic                   credit_ok;
  logic                   fetch_fire;
  logic                   resp_current;
  logic                   enq_v;
  logic                   deq_v;

  // Queued plus outstanding requests never exceed the depth, so the queue cannot overflow.
  assign credit_ok     = ({1'b0, count} + {1'b0, inflight_q}) < (CNT_W + 1)'(QUEUE_DEPTH_P);
  assign fetch_v_o     = !reset_i && !be_fe_mispredict_i && credit_ok;
  assign fetch_pc_o    = pc_q;
  assign fetch_epoch_o = epoch_q;
  assign fetch_fire    = fetch_v_o && fetch_ready_i;
  assign resp_current  = dec_v_i && (dec_epoch_i == epoch_q) && !be_fe_mispredict_i;
  assign deq_v         = (count != '0) && rename_decode_ready_i && !be_fe_mispredict_i;

`ifdef FE_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass      = resp_current && (count == '0);
  assign decoded_v_o = (count != '0) || bypass;
  assign decoded_o   = bypass ? dec_instr_i : head_data;
  assign enq_v       = resp_current && !(bypass && rename_decode_ready_i);
`else
  assign decoded_v_o = (count != '0);
  assign decoded_o   = head_data;
  assign enq_v       = resp_current;
`endif

  // Stale responses still return their credit, including during a mispredict.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q       <= RESET_PC_P;
      epoch_q    <= 1'b0;
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_q + CNT_W'(fetch_fire) - CNT_W'(dec_v_i);
      if (be_fe_mispredict_i) begin
        pc_q    <= be_fe_redirected_pc_i;
        epoch_q <= ~epoch_q;
      end else if (fetch_fire) begin
        pc_q <= pc_q + WORD_SIZE_P'(PC_STEP_P);
      end
    end
  end

  fe_ring_buffer #(
    .DEPTH_P (QUEUE_DEPTH_P),
    .WIDTH_P (INSTR_W)
  ) u_ring (
    .clk       (clk_i),
    .reset     (reset_i),
    .flush     (be_fe_mispredict_i),
    .enq_v     (enq_v),
    .enq_data  (dec_instr_i),
    .deq_v     (deq_v),
    .head_data (head_data),
    .count     (count)
  );

endmodule

// File: tb/tb_fe_decode_queue.sv
// Self-checking bench for fe_decode_queue: a directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_fe_decode_queue;
  import fe_decode_queue_pkg::*;

  localparam int DEPTH = FE_QUEUE_DEPTH;
  localparam int W     = WORD_SIZE_P;
  localparam int IW    = DECODED_INSTRUCTION_WIDTH;
`ifdef FE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset_i;
  logic          fetch_v_o;
  logic [W-1:0]  fetch_pc_o;
  logic          fetch_epoch_o;
  logic          fetch_ready_i;
  logic          dec_v_i;
  logic          dec_epoch_i;
  logic [IW-1:0] dec_instr_i;
  logic [IW-1:0] decoded_o;
  logic          decoded_v_o;
  logic          rename_decode_ready_i;
  logic          be_fe_mispredict_i;
  logic [W-1:0]  be_fe_redirected_pc_i;

  fe_decode_queue #(
    .QUEUE_DEPTH_P (DEPTH),
    .WORD_SIZE_P   (W),
    .PC_STEP_P     (2),
    .RESET_PC_P    ('0)
  ) dut (
    .clk_i                 (clk),
    .reset_i               (reset_i),
    .fetch_v_o             (fetch_v_o),
    .fetch_pc_o            (fetch_pc_o),
    .fetch_epoch_o         (fetch_epoch_o),
    .fetch_ready_i         (fetch_ready_i),
    .dec_v_i               (dec_v_i),
    .dec_epoch_i           (dec_epoch_i),
    .dec_instr_i           (dec_instr_i),
    .decoded_o             (decoded_o),
    .decoded_v_o           (decoded_v_o),
    .rename_decode_ready_i (rename_decode_ready_i),
    .be_fe_mispredict_i    (be_fe_mispredict_i),
    .be_fe_redirected_pc_i (be_fe_redirected_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO contents, outstanding requests in issue order, PC and epoch.
  logic [IW-1:0] mq[$];
  fe_req_t       pend[$];
  logic [W-1:0]  m_pc;
  logic          m_epoch;

  typedef struct {
    logic          fr;
    logic          dv;
    logic          rr;
    logic [IW-1:0] instr;
    logic          exp_fv;
    logic [W-1:0]  exp_pc;
    logic          exp_dv;
    logic [IW-1:0] exp_do;
  } vec_t;

  vec_t tbl[7];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    fetch_ready_i         = 1'b0;
    dec_v_i               = 1'b0;
    dec_epoch_i           = 1'b0;
    dec_instr_i           = '0;
    rename_decode_ready_i = 1'b0;
    be_fe_mispredict_i    = 1'b0;
    be_fe_redirected_pc_i = '0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    driveIdle();
    reset_i = 1'b1;
    #1;
    checkOutput("reset_fetch_v", 32'(fetch_v_o), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("reset_decoded_v", 32'(decoded_v_o), 32'd0);
    reset_i = 1'b0;
    mq.delete();
    pend.delete();
    m_pc    = '0;
    m_epoch = 1'b0;
  endtask

  // One clock of stimulus: drive, check against the model, then advance the model.
  task automatic applyStimulus(input logic fr, input logic want_dv, input logic [IW-1:0] instr,
                               input logic rr, input logic mp, input logic [W-1:0] rpc);
    logic          dv, dep, exp_fv, byp, exp_dv, had;
    logic [IW-1:0] exp_do;
    logic [IW-1:0] dropped;
    fe_req_t       req;
    @(negedge clk);
    dv  = want_dv && (pend.size() != 0);
    dep = dv ? pend[0].epoch : 1'b0;
    fetch_ready_i         = fr;
    dec_v_i               = dv;
    dec_epoch_i           = dep;
    dec_instr_i           = instr;
    rename_decode_ready_i = rr;
    be_fe_mispredict_i    = mp;
    be_fe_redirected_pc_i = rpc;
    #1;
    had    = (mq.size() != 0);
    exp_fv = !mp && ((mq.size() + pend.size()) < DEPTH);
    byp    = BYP && !had && dv && (dep == m_epoch) && !mp;
    exp_dv = had || byp;
    exp_do = had ? mq[0] : instr;
    checkOutput("fetch_v", 32'(fetch_v_o), 32'(exp_fv));
    if (exp_fv) begin
      checkOutput("fetch_pc", 32'(fetch_pc_o), 32'(m_pc));
      checkOutput("fetch_epoch", 32'(fetch_epoch_o), 32'(m_epoch));
    end
    checkOutput("decoded_v", 32'(decoded_v_o), 32'(exp_dv));
    if (exp_dv) checkOutput("decoded", decoded_o, exp_do);

    if (dv) req = pend.pop_front();
    if (mp) begin
      mq.delete();
      m_pc    = rpc;
      m_epoch = ~m_epoch;
    end else begin
      if (had && rr) dropped = mq.pop_front();
      if (dv && (dep == m_epoch) && !(byp && rr)) mq.push_back(instr);
      if (exp_fv && fr) begin
        req.pc    = m_pc;
        req.epoch = m_epoch;
        pend.push_back(req);
        m_pc = m_pc + W'(2);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    driveIdle();

    // Directed table: in-order delivery with a one-cycle decoder.
    tbl[0] = '{fr:1'b1, dv:1'b0, rr:1'b0, instr:32'h0,      exp_fv:1'b1, exp_pc:16'd0,  exp_dv:1'b0, exp_do:32'h0};
    tbl[1] = '{fr:1'b1, dv:1'b1, rr:1'b0, instr:32'h1000,   exp_fv:1'b1, exp_pc:16'd2,  exp_dv:BYP,  exp_do:32'h1000};
    tbl[2] = '{fr:1'b1, dv:1'b1, rr:1'b1, instr:32'h1002,   exp_fv:1'b1, exp_pc:16'd4,  exp_dv:1'b1, exp_do:32'h1000};
    tbl[3] = '{fr:1'b1, dv:1'b1, rr:1'b1, instr:32'h1004,   exp_fv:1'b1, exp_pc:16'd6,  exp_dv:1'b1, exp_do:32'h1002};
    tbl[4] = '{fr:1'b1, dv:1'b0, rr:1'b1, instr:32'h0,      exp_fv:1'b1, exp_pc:16'd8,  exp_dv:1'b1, exp_do:32'h1004};
    tbl[5] = '{fr:1'b0, dv:1'b1, rr:1'b1, instr:32'h1006,   exp_fv:1'b1, exp_pc:16'd10, exp_dv:BYP,  exp_do:32'h1006};
    tbl[6] = '{fr:1'b0, dv:1'b0, rr:1'b1, instr:32'h0,      exp_fv:1'b1, exp_pc:16'd10, exp_dv:!BYP, exp_do:32'h1006};

    resetDut();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      fetch_ready_i         = tbl[i].fr;
      dec_v_i               = tbl[i].dv;
      dec_epoch_i           = 1'b0;
      dec_instr_i           = tbl[i].instr;
      rename_decode_ready_i = tbl[i].rr;
      be_fe_mispredict_i    = 1'b0;
      #1;
      checkOutput($sformatf("tbl%0d_fetch_v", i), 32'(fetch_v_o), 32'(tbl[i].exp_fv));
      if (tbl[i].exp_fv) checkOutput($sformatf("tbl%0d_pc", i), 32'(fetch_pc_o), 32'(tbl[i].exp_pc));
      checkOutput($sformatf("tbl%0d_decoded_v", i), 32'(decoded_v_o), 32'(tbl[i].exp_dv));
      if (tbl[i].exp_dv) checkOutput($sformatf("tbl%0d_decoded", i), decoded_o, tbl[i].exp_do);
    end

    // Credit limit: exactly DEPTH requests accepted while rename stalls.
    resetDut();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("credit_stall", 32'(fetch_v_o), 32'd0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("credit_return", 32'(fetch_v_o), 32'd1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0, '0);

    // Mispredict with 3 queued, 2 in flight, colliding with enq/deq/fetch-ready.
    resetDut();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 32'hDEAD0001, 1'b1, 1'b1, 16'h0100);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("redirect_pc", 32'(fetch_pc_o), 32'h0100);
    checkOutput("redirect_epoch", 32'(fetch_epoch_o), 32'd1);
    checkOutput("redirect_flushed", 32'(decoded_v_o), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, '0);

    // PC wrap and pointer wrap across many enqueues.
    resetDut();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 16'hFFFE);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("pc_wrap", 32'(fetch_pc_o), 32'h0000);
    for (int i = 0; i < 45; i++) applyStimulus(1'b1, 1'b1, $urandom, (i % 3) != 0, 1'b0, '0);

    // Empty-queue response: same-cycle only with the bypass built in.
    resetDut();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 32'hCAFE0001, 1'b1, 1'b0, '0);
    checkOutput("bypass_same_cycle", 32'(decoded_v_o), 32'(BYP));
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    checkOutput("bypass_next_cycle", 32'(decoded_v_o), 32'(!BYP));

    // Randomized traffic against the model.
    resetDut();
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3, $urandom,
                    $urandom_range(0, 4) < 3, $urandom_range(0, 31) == 0, W'($urandom));
    end

    @(negedge clk);
    driveIdle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fe_decode_queue.md
Name: fe_decode_queue

Overview:
- Front-end producer for the backend's decoded-instruction interface; the back end consumes `decoded_o`/`decoded_v_o` and returns `rename_decode_ready_i`.
- Generates sequential fetch PCs (static not-taken), tags each request with an epoch, and buffers decoder responses in a credit-checked ring queue.
- Consumes the back end's `be_fe_mispredict_i`/`be_fe_redirected_pc_i`: flushes the queue, redirects the PC and drops stale responses.

Parameters:
- QUEUE_DEPTH_P, 8, queue entries; power of 2, at least 2.
- WORD_SIZE_P, 16, PC width.
- PC_STEP_P, 2, PC increment per accepted fetch.
- RESET_PC_P, 0, fetch PC after reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- fetch_v_o  out  1  fetch request valid.
- fetch_pc_o  out  WORD_SIZE_P  fetch PC.
- fetch_epoch_o  out  1  epoch tag of the request.
- fetch_ready_i  in  1  fetch/decode path accepts the request.
- dec_v_i  in  1  decoder response valid; no backpressure.
- dec_epoch_i  in  1  epoch returned with the response.
- dec_instr_i  in  DECODED_INSTRUCTION_WIDTH  decoded instruction.
- decoded_o  out  DECODED_INSTRUCTION_WIDTH  queue head to rename.
- decoded_v_o  out  1  head valid.
- rename_decode_ready_i  in  1  rename accepts the head.
- be_fe_mispredict_i  in  1  flush/redirect pulse.
- be_fe_redirected_pc_i  in  WORD_SIZE_P  redirect target.

Behaviour:
- Reset (synchronous): pc = RESET_PC_P; epoch = 0; head = tail = count = inflight = 0; fetch_v_o = 0; decoded_v_o = 0.
- count holds queued entries; inflight holds accepted requests not yet answered, including stale ones. Both are $clog2(QUEUE_DEPTH_P)+1 bits wide.
- Credit rule: fetch_v_o = !reset_i & !be_fe_mispredict_i & (count + inflight < QUEUE_DEPTH_P). With this rule the queue can never overflow.
- Fetch accept (fetch_v_o & fetch_ready_i): pc += PC_STEP_P, wrapping modulo 2^WORD_SIZE_P; inflight++.
- Every dec_v_i decrements inflight.
- A response enqueues at tail only if dec_epoch_i == epoch and there is no mispredict that cycle; otherwise it is silently dropped.
- Dequeue on decoded_v_o & rename_decode_ready_i. head and tail wrap modulo QUEUE_DEPTH_P.
- decoded_o = mem[head]; decoded_v_o = (count != 0). Enqueue-to-visible latency is 1 cycle.
- Enqueue and dequeue in the same cycle: count is unchanged. Full and empty are distinguished by count, not by pointer compare.
- Mispredict has priority over everything:
  - next cycle: pc = be_fe_redirected_pc_i, epoch toggles, head = tail = count = 0;
  - enqueue and dequeue in that cycle are ignored;
  - inflight still decrements on a dec_v_i that cycle;
  - the first redirected request is issued the following cycle with the new epoch.
- Back-to-back mispredicts: the last one wins.
- Stale responses arriving after a redirect carry the old epoch; they are dropped but still return credit.
- No FSM beyond these registers: the block is idle when count and inflight are 0.

Optional Feature:
- Macro: FE_QUEUE_BYPASS_EN.
- Defined: when count == 0 and a valid, current-epoch response arrives without a mispredict, it drives decoded_o/decoded_v_o in the same cycle.
  - If rename_decode_ready_i is 1, the response is consumed and not written.
  - Otherwise it is enqueued normally.
- Undefined: minimum latency is 1 cycle; decoded_v_o is purely register-derived.

Decomposition:
- Shared package holds: DECODED_INSTRUCTION_WIDTH, WORD_SIZE_P, RESET_PC_P, FE_QUEUE_DEPTH, and typedef fe_req_t {pc, epoch}.
- One sub-module, fe_ring_buffer: storage, head/tail/count, enq/deq/flush ports.
- Parent fe_decode_queue keeps the PC, epoch, inflight, credit and bypass logic.

Test Plan:
- Reset, then fetch_ready_i = 1, decoder returning in 1 cycle, rename ready → fetch_pc_o 0, 2, 4, ...; decoded_o appears in order 1 cycle after each dec_v_i.
- rename_decode_ready_i = 0 with DEPTH 8 → exactly 8 requests accepted, then fetch_v_o = 0; with ready = 1, one dequeue → fetch_v_o rises next cycle; no entry lost.
- 3 entries queued, 2 in flight, mispredict to 0x0100 → count = 0 next cycle; the 2 old-epoch responses are dropped; next fetch_pc_o = 0x0100 with the toggled epoch.
- Mispredict in the same cycle as enqueue, dequeue and fetch-ready → no enqueue; no fetch accepted that cycle; inflight decremented.
- PC at 0xFFFE with step 2 → next fetch_pc_o = 0x0000; pointer wrap after 20 enqueues keeps FIFO order.
- FE_QUEUE_BYPASS_EN defined, queue empty, dec_v_i with ready = 1 → decoded_v_o in the same cycle and count stays 0; with the macro undefined → decoded_v_o the next cycle.
